// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-network datapath blocks.
// Used by the weight-load sequencer and the activation/sum stages.
package nn_pkg;

    localparam int NN_LAYER_STRIDE = 16;
    localparam int NN_NUM_LAYERS   = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_SUM,
        S_DONE
    } wls_state_t;

    function automatic int CLOG2_MIN1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_load_sequencer.sv
// Streams one layer's weight block from the weight RAM into the neuron
// units' local register files, then fires the accumulate trigger.
module weight_load_sequencer
    import nn_pkg::*;
#(
    parameter int ADDR_W           = 10,
    parameter int NUM_UNITS        = 4,
    parameter int WEIGHTS_PER_UNIT = 4,
    parameter int RAM_LATENCY      = 2,
    parameter int NUM_LAYERS       = NN_NUM_LAYERS,
    parameter int LAYER_STRIDE     = NN_LAYER_STRIDE,
    parameter int LAYER_W          = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [LAYER_W-1:0]                      layer,
    input  logic                                    abort,
    output logic [ADDR_W-1:0]                       ram_addr,
    output logic                                    ram_en,
    output logic [CLOG2_MIN1(NUM_UNITS)-1:0]        unit_sel,
    output logic [CLOG2_MIN1(WEIGHTS_PER_UNIT)-1:0] unit_addr,
    output logic                                    unit_write,
    output logic                                    sum_trigger,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err
);

    localparam int UNIT_W = CLOG2_MIN1(NUM_UNITS);
    localparam int WORD_W = CLOG2_MIN1(WEIGHTS_PER_UNIT);
    localparam int LAT_W  = CLOG2_MIN1(RAM_LATENCY);

    localparam logic [UNIT_W-1:0] LAST_UNIT = UNIT_W'(NUM_UNITS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WEIGHTS_PER_UNIT - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RAM_LATENCY - 1);
    localparam logic [31:0]       NL        = NUM_LAYERS;

    generate
        if (NUM_UNITS * WEIGHTS_PER_UNIT > LAYER_STRIDE) begin : g_bad_stride
            $error("weight block of one layer overlaps the next layer");
        end
        if (NUM_UNITS < 1 || WEIGHTS_PER_UNIT < 1 || RAM_LATENCY < 1) begin : g_bad_size
            $error("unit count, words per unit and RAM latency must be >= 1");
        end
    endgenerate

    wls_state_t          state;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W-1:0]   offset;
    logic [LAT_W-1:0]    lat_cnt;
    logic                sum_cnt;
    logic [ADDR_W-1:0]   layer_base;
    logic [ADDR_W-1:0]   offset_nxt;
    logic                layer_ok;
    logic                last_word;

    assign layer_base = ADDR_W'(layer) * ADDR_W'(LAYER_STRIDE);
    assign layer_ok   = 32'(layer) < NL;
    assign offset_nxt = offset + ADDR_W'(1);
    assign last_word  = (unit_sel == LAST_UNIT) && (unit_addr == LAST_WORD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            base        <= '0;
            offset      <= '0;
            lat_cnt     <= '0;
            sum_cnt     <= 1'b0;
            ram_addr    <= '0;
            ram_en      <= 1'b0;
            unit_sel    <= '0;
            unit_addr   <= '0;
            unit_write  <= 1'b0;
            sum_trigger <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            ram_en      <= 1'b0;
            unit_write  <= 1'b0;
            sum_trigger <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            // Abort is only meaningful once a load is in flight.
            if (state != S_IDLE && abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && layer_ok) begin
                            base      <= layer_base;
                            offset    <= '0;
                            unit_sel  <= '0;
                            unit_addr <= '0;
                            ram_addr  <= layer_base;
                            ram_en    <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_ISSUE;
                        end else if (start) begin
                            err <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        lat_cnt <= LAT_LOAD;
                        state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (lat_cnt == '0) begin
                            unit_write <= 1'b1;
                            state      <= S_WRITE;
                        end else begin
                            lat_cnt <= lat_cnt - LAT_W'(1);
                        end
                    end
                    S_WRITE: begin
                        if (last_word) begin
                            sum_trigger <= 1'b1;
                            sum_cnt     <= 1'b0;
                            state       <= S_SUM;
                        end else begin
                            // One running offset spans all units of the layer.
                            offset   <= offset_nxt;
                            ram_addr <= base + offset_nxt;
                            ram_en   <= 1'b1;
                            state    <= S_ISSUE;
                            if (unit_addr == LAST_WORD) begin
                                unit_addr <= '0;
                                unit_sel  <= unit_sel + UNIT_W'(1);
                            end else begin
                                unit_addr <= unit_addr + WORD_W'(1);
                            end
                        end
                    end
                    S_SUM: begin
                        if (!sum_cnt) begin
                            sum_cnt     <= 1'b1;
                            sum_trigger <= 1'b1;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench for weight_load_sequencer across four parameter sets:
// defaults, a small 2x3 array, a 5-bit address bus, and a wrapping base.
module tb_weight_load_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       st[4];
    logic [1:0] ly[4];
    logic       ab[4];
    logic       en[4], wr[4], sm[4], bz[4], dn[4], er[4];
    logic [9:0] a0, a1;
    logic [4:0] a2, a3;
    logic [1:0] us0, ua0, ua1, us2, ua2, ua3;
    logic       us1, us3;

    int passed = 0;
    int total = 0;
    int busy_n[4], done_n[4], sum_n[4], err_n[4], en_n[4];
    int done_c[4], sum_c[4], last_busy[4], en_c[4];
    int wa[4][$];
    int ws[4][$];
    int wu[4][$];
    int wc[4][$];
    int sc;
    bit tmo;

    weight_load_sequencer u0 (
        .clk(clk), .reset(reset), .start(st[0]), .layer(ly[0]), .abort(ab[0]),
        .ram_addr(a0), .ram_en(en[0]), .unit_sel(us0), .unit_addr(ua0),
        .unit_write(wr[0]), .sum_trigger(sm[0]), .busy(bz[0]), .done(dn[0]),
        .err(er[0])
    );

    weight_load_sequencer #(
        .NUM_UNITS(2), .WEIGHTS_PER_UNIT(3), .RAM_LATENCY(1)
    ) u1 (
        .clk(clk), .reset(reset), .start(st[1]), .layer(ly[1]), .abort(ab[1]),
        .ram_addr(a1), .ram_en(en[1]), .unit_sel(us1), .unit_addr(ua1),
        .unit_write(wr[1]), .sum_trigger(sm[1]), .busy(bz[1]), .done(dn[1]),
        .err(er[1])
    );

    weight_load_sequencer #(.ADDR_W(5)) u2 (
        .clk(clk), .reset(reset), .start(st[2]), .layer(ly[2]), .abort(ab[2]),
        .ram_addr(a2), .ram_en(en[2]), .unit_sel(us2), .unit_addr(ua2),
        .unit_write(wr[2]), .sum_trigger(sm[2]), .busy(bz[2]), .done(dn[2]),
        .err(er[2])
    );

    weight_load_sequencer #(
        .ADDR_W(5), .NUM_UNITS(1), .RAM_LATENCY(1), .LAYER_STRIDE(15)
    ) u3 (
        .clk(clk), .reset(reset), .start(st[3]), .layer(ly[3]), .abort(ab[3]),
        .ram_addr(a3), .ram_en(en[3]), .unit_sel(us3), .unit_addr(ua3),
        .unit_write(wr[3]), .sum_trigger(sm[3]), .busy(bz[3]), .done(dn[3]),
        .err(er[3])
    );

    task automatic mon(input int i, input int addr, input int sel, input int ua);
        if (bz[i]) begin busy_n[i]++; last_busy[i] = cyc; end
        if (dn[i]) begin done_n[i]++; done_c[i] = cyc; end
        if (sm[i]) begin sum_n[i]++; sum_c[i] = cyc; end
        if (er[i]) err_n[i]++;
        if (en[i]) begin en_n[i]++; if (en_n[i] == 1) en_c[i] = cyc; end
        if (wr[i]) begin
            wa[i].push_back(addr);
            ws[i].push_back(sel);
            wu[i].push_back(ua);
            wc[i].push_back(cyc);
        end
    endtask

    always @(negedge clk) begin
        mon(0, int'(a0), int'(us0), int'(ua0));
        mon(1, int'(a1), int'(us1), int'(ua1));
        mon(2, int'(a2), int'(us2), int'(ua2));
        mon(3, int'(a3), int'(us3), int'(ua3));
    end

    task automatic clear(input int i);
        busy_n[i] = 0; done_n[i] = 0; sum_n[i] = 0; err_n[i] = 0; en_n[i] = 0;
        done_c[i] = -1; sum_c[i] = -1; last_busy[i] = -1; en_c[i] = -1;
        wa[i].delete(); ws[i].delete(); wu[i].delete(); wc[i].delete();
    endtask

    task automatic do_start(input int i, input logic [1:0] l);
        @(posedge clk);
        #1 st[i] = 1'b1; ly[i] = l;
        @(posedge clk);
        #1 st[i] = 1'b0;
        sc = cyc;
    endtask

    task automatic wait_idle(input int i, input int budget, output bit to);
        to = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!bz[i]) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (a0 !== 10'd0) $display("FAIL reset_addr: got %0d want 0", a0);
        else passed++;
        total++;
        if ({en[0], wr[0], sm[0], bz[0], dn[0], er[0]} !== 6'b0)
            $display("FAIL reset_strobes: got %b want 000000",
                     {en[0], wr[0], sm[0], bz[0], dn[0], er[0]});
        else passed++;
        total++;
        if ({us0, ua0} !== 4'd0) $display("FAIL reset_sel: got %b want 0000", {us0, ua0});
        else passed++;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_full_load();
        clear(0);
        do_start(0, 2'd1);
        wait_idle(0, 200, tmo);
        total++;
        if (tmo !== 1'b0) $display("FAIL full_timeout: got busy stuck want idle");
        else passed++;
        total++;
        if (wa[0].size() != 16) $display("FAIL full_count: got %0d want 16", wa[0].size());
        else passed++;
        for (int k = 0; k < wa[0].size(); k++) begin
            total++;
            if (wa[0][k] != 16 + k) $display("FAIL full_addr[%0d]: got %0d want %0d", k, wa[0][k], 16 + k);
            else passed++;
            total++;
            if (ws[0][k] != k / 4 || wu[0][k] != k % 4)
                $display("FAIL full_sel[%0d]: got %0d,%0d want %0d,%0d", k, ws[0][k], wu[0][k], k / 4, k % 4);
            else passed++;
            if (k > 0) begin
                total++;
                if (wc[0][k] - wc[0][k-1] != 4)
                    $display("FAIL full_gap[%0d]: got %0d want 4", k, wc[0][k] - wc[0][k-1]);
                else passed++;
            end
        end
        total++;
        if (en_c[0] != sc) $display("FAIL first_issue: got %0d want %0d", en_c[0], sc);
        else passed++;
        total++;
        if (wc[0].size() == 0 || wc[0][0] != sc + 3)
            $display("FAIL first_write: got %0d want %0d", wc[0].size() ? wc[0][0] : -1, sc + 3);
        else passed++;
        total++;
        if (busy_n[0] != 67) $display("FAIL full_busy: got %0d want 67", busy_n[0]);
        else passed++;
        total++;
        if (sum_n[0] != 2 || sum_c[0] != done_c[0] - 1)
            $display("FAIL full_sum: got %0d cycles ending %0d want 2 ending %0d", sum_n[0], sum_c[0], done_c[0] - 1);
        else passed++;
        total++;
        if (done_n[0] != 1 || done_c[0] != last_busy[0])
            $display("FAIL full_done: got %0d at %0d want 1 at %0d", done_n[0], done_c[0], last_busy[0]);
        else passed++;
    endtask

    task automatic test_bad_layer();
        clear(0);
        do_start(0, 2'd3);
        repeat (5) @(negedge clk);
        total++;
        if (err_n[0] != 1) $display("FAIL bad_err: got %0d want 1", err_n[0]);
        else passed++;
        total++;
        if (busy_n[0] + en_n[0] + wa[0].size() != 0)
            $display("FAIL bad_quiet: got busy %0d en %0d wr %0d want 0", busy_n[0], en_n[0], wa[0].size());
        else passed++;
    endtask

    task automatic test_abort();
        clear(0);
        do_start(0, 2'd1);
        tmo = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wa[0].size() == 5) begin tmo = 1'b0; break; end
        end
        total++;
        if (tmo !== 1'b0) $display("FAIL abort_reach: got %0d writes want 5", wa[0].size());
        else passed++;
        @(posedge clk);
        @(posedge clk);
        #1 ab[0] = 1'b1;
        @(posedge clk);
        #1 ab[0] = 1'b0;
        @(negedge clk);
        total++;
        if (bz[0] !== 1'b0) $display("FAIL abort_idle: got busy %b want 0", bz[0]);
        else passed++;
        repeat (10) @(negedge clk);
        total++;
        if (wa[0].size() != 5 || done_n[0] != 0 || sum_n[0] != 0)
            $display("FAIL abort_quiet: got wr %0d done %0d sum %0d want 5 0 0", wa[0].size(), done_n[0], sum_n[0]);
        else passed++;
        clear(0);
        do_start(0, 2'd0);
        wait_idle(0, 200, tmo);
        total++;
        if (tmo || wa[0].size() != 16 || done_n[0] != 1 || busy_n[0] != 67)
            $display("FAIL abort_rerun: got wr %0d done %0d busy %0d want 16 1 67", wa[0].size(), done_n[0], busy_n[0]);
        else passed++;
        for (int k = 0; k < wa[0].size(); k++) begin
            total++;
            if (wa[0][k] != k) $display("FAIL rerun_addr[%0d]: got %0d want %0d", k, wa[0][k], k);
            else passed++;
        end
    endtask

    task automatic test_start_ignored();
        clear(0);
        do_start(0, 2'd1);
        repeat (10) @(posedge clk);
        #1 st[0] = 1'b1; ly[0] = 2'd0;
        @(posedge clk);
        #1 st[0] = 1'b0;
        wait_idle(0, 200, tmo);
        total++;
        if (tmo || wa[0].size() != 16 || busy_n[0] != 67 || done_n[0] != 1)
            $display("FAIL ignore_run: got wr %0d busy %0d done %0d want 16 67 1", wa[0].size(), busy_n[0], done_n[0]);
        else passed++;
        for (int k = 0; k < wa[0].size(); k++) begin
            total++;
            if (wa[0][k] != 16 + k) $display("FAIL ignore_addr[%0d]: got %0d want %0d", k, wa[0][k], 16 + k);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear(0);
        do_start(0, 2'd2);
        repeat (9) @(posedge clk);
        @(negedge clk);
        total++;
        if (bz[0] !== 1'b1 || a0 < 10'd32) $display("FAIL midreset_pre: got busy %b addr %0d want 1 >=32", bz[0], a0);
        else passed++;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({a0, us0, ua0, en[0], wr[0], sm[0], bz[0], dn[0], er[0]} !== 20'd0)
            $display("FAIL midreset_out: got addr %0d busy %b en %b sel %0d,%0d want all 0", a0, bz[0], en[0], us0, ua0);
        else passed++;
        #1 reset = 1'b0;
        n = wa[0].size();
        repeat (20) @(negedge clk);
        total++;
        if (wa[0].size() != n || bz[0] !== 1'b0) $display("FAIL midreset_stay: got %0d writes want %0d", wa[0].size(), n);
        else passed++;
    endtask

    task automatic test_small();
        clear(1);
        do_start(1, 2'd2);
        wait_idle(1, 100, tmo);
        total++;
        if (tmo || wa[1].size() != 6 || busy_n[1] != 21 || done_n[1] != 1)
            $display("FAIL small_run: got wr %0d busy %0d done %0d want 6 21 1", wa[1].size(), busy_n[1], done_n[1]);
        else passed++;
        for (int k = 0; k < wa[1].size(); k++) begin
            total++;
            if (wa[1][k] != 32 + k || ws[1][k] != k / 3 || wu[1][k] != k % 3)
                $display("FAIL small_addr[%0d]: got %0d (%0d,%0d) want %0d (%0d,%0d)",
                         k, wa[1][k], ws[1][k], wu[1][k], 32 + k, k / 3, k % 3);
            else passed++;
            if (k > 0) begin
                total++;
                if (wc[1][k] - wc[1][k-1] != 3)
                    $display("FAIL small_gap[%0d]: got %0d want 3", k, wc[1][k] - wc[1][k-1]);
                else passed++;
            end
        end
    endtask

    task automatic test_narrow();
        clear(2);
        do_start(2, 2'd1);
        wait_idle(2, 200, tmo);
        total++;
        if (tmo || wa[2].size() != 16 || busy_n[2] != 67)
            $display("FAIL narrow_run: got wr %0d busy %0d want 16 67", wa[2].size(), busy_n[2]);
        else passed++;
        for (int k = 0; k < wa[2].size(); k++) begin
            total++;
            if (wa[2][k] != 16 + k) $display("FAIL narrow_addr[%0d]: got %0d want %0d", k, wa[2][k], 16 + k);
            else passed++;
        end
        clear(3);
        do_start(3, 2'd2);
        wait_idle(3, 100, tmo);
        total++;
        if (tmo || wa[3].size() != 4 || busy_n[3] != 15 || done_n[3] != 1)
            $display("FAIL wrap_run: got wr %0d busy %0d done %0d want 4 15 1", wa[3].size(), busy_n[3], done_n[3]);
        else passed++;
        for (int k = 0; k < wa[3].size(); k++) begin
            total++;
            if (wa[3][k] != (30 + k) % 32)
                $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, wa[3][k], (30 + k) % 32);
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            st[i] = 1'b0;
            ly[i] = 2'd0;
            ab[i] = 1'b0;
            clear(i);
        end
        test_reset();
        test_full_load();
        test_bad_layer();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_small();
        test_narrow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
